// File: rtl/vdp_super_palette_if.sv
// Pixel-side and CPU-side signal bundle for the super-res palette.
// master = pixel stage / CPU, slave = palette.
interface vdp_super_palette_if;
   localparam int unsigned DW = 8;

   logic [DW-1:0] palette_addr;
   logic [DW-1:0] palette_r;
   logic [DW-1:0] palette_g;
   logic [DW-1:0] palette_b;
   logic          cpu_index_wr;
   logic [DW-1:0] cpu_index;
   logic          cpu_data_wr;
   logic [DW-1:0] cpu_data;
   logic          cpu_rd_req;
   logic [DW-1:0] cpu_rd_data;

   modport master (
      output palette_addr, cpu_index_wr, cpu_index, cpu_data_wr, cpu_data, cpu_rd_req,
      input  palette_r, palette_g, palette_b, cpu_rd_data
   );

   modport slave (
      input  palette_addr, cpu_index_wr, cpu_index, cpu_data_wr, cpu_data, cpu_rd_req,
      output palette_r, palette_g, palette_b, cpu_rd_data
   );
endinterface

// File: rtl/vdp_super_palette.sv
// 256 x 24-bit RGB palette with grey-ramp init fill and CPU triplet loading.
// Define VDP_SUPER_PALETTE_READBACK_EN to build the CPU readback port.
module vdp_super_palette #(
   parameter int unsigned INIT_LEVEL_SHIFT = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   vdp_super_palette_if.slave  bus,
   output logic                init_done
);
   localparam int unsigned DW      = 8;
   localparam int unsigned AW      = 8;
   localparam int unsigned ENTRIES = 256;

   typedef enum logic [1:0] {ST_INIT, ST_PH_R, ST_PH_G, ST_PH_B} state_t;

   state_t            state;
   logic [AW-1:0]     init_ctr;
   logic [AW-1:0]     wr_index;
   logic [DW-1:0]     hold_r;
   logic [DW-1:0]     hold_g;
   logic [3*DW-1:0]   mem [ENTRIES];

   logic              we_c;
   logic [AW-1:0]     waddr_c;
   logic [3*DW-1:0]   wdata_c;
   logic [DW-1:0]     grey_c;

   assign grey_c = DW'(init_ctr << INIT_LEVEL_SHIFT);

   // Single write port: init fill, or a CPU commit on the B byte.
   // An index load in the same cycle resets the phase, so it can never commit.
   always_comb begin
      we_c    = 1'b0;
      waddr_c = wr_index;
      wdata_c = {hold_r, hold_g, bus.cpu_data};
      if (state == ST_INIT) begin
         we_c    = 1'b1;
         waddr_c = init_ctr;
         wdata_c = {grey_c, grey_c, grey_c};
      end else if (bus.cpu_data_wr && !bus.cpu_index_wr && state == ST_PH_B) begin
         we_c = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we_c) mem[waddr_c] <= wdata_c;
   end

   // Init sequencer and CPU write-phase machine.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_INIT;
         init_ctr  <= '0;
         init_done <= 1'b0;
         wr_index  <= '0;
         hold_r    <= '0;
         hold_g    <= '0;
      end else if (state == ST_INIT) begin
         init_ctr <= init_ctr + AW'(1);
         if (init_ctr == AW'(ENTRIES - 1)) begin
            init_done <= 1'b1;
            state     <= ST_PH_R;
         end
      end else if (bus.cpu_index_wr) begin
         wr_index <= bus.cpu_index;
         if (bus.cpu_data_wr) begin
            hold_r <= bus.cpu_data;
            state  <= ST_PH_G;
         end else begin
            state  <= ST_PH_R;
         end
      end else if (bus.cpu_data_wr) begin
         case (state)
            ST_PH_R: begin
               hold_r <= bus.cpu_data;
               state  <= ST_PH_G;
            end
            ST_PH_G: begin
               hold_g <= bus.cpu_data;
               state  <= ST_PH_B;
            end
            default: begin
               wr_index <= wr_index + AW'(1);
               state    <= ST_PH_R;
            end
         endcase
      end
   end

   // Pixel read with write-through bypass so a same-cycle commit is visible immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.palette_r <= '0;
         bus.palette_g <= '0;
         bus.palette_b <= '0;
      end else if (we_c && waddr_c == bus.palette_addr) begin
         {bus.palette_r, bus.palette_g, bus.palette_b} <= wdata_c;
      end else begin
         {bus.palette_r, bus.palette_g, bus.palette_b} <= mem[bus.palette_addr];
      end
   end

`ifdef VDP_SUPER_PALETTE_READBACK_EN
   logic [AW-1:0]   rd_index;
   logic [1:0]      rd_phase;
   logic [3*DW-1:0] rd_entry_c;
   logic [DW-1:0]   rd_byte_c;

   assign rd_entry_c = mem[rd_index];

   always_comb begin
      rd_byte_c = rd_entry_c[DW-1:0];
      case (rd_phase)
         2'd0:    rd_byte_c = rd_entry_c[3*DW-1:2*DW];
         2'd1:    rd_byte_c = rd_entry_c[2*DW-1:DW];
         default: rd_byte_c = rd_entry_c[DW-1:0];
      endcase
   end

   // Readback cursor walks R,G,B then advances the entry; an index load takes priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_index        <= '0;
         rd_phase        <= '0;
         bus.cpu_rd_data <= '0;
      end else if (state != ST_INIT) begin
         if (bus.cpu_index_wr) begin
            rd_index <= bus.cpu_index;
            rd_phase <= '0;
         end else if (bus.cpu_rd_req) begin
            bus.cpu_rd_data <= rd_byte_c;
            if (rd_phase == 2'd2) begin
               rd_phase <= '0;
               rd_index <= rd_index + AW'(1);
            end else begin
               rd_phase <= rd_phase + 2'd1;
            end
         end
      end
   end
`else
   logic unused_rd_req;
   assign unused_rd_req   = bus.cpu_rd_req;
   assign bus.cpu_rd_data = '0;
`endif

endmodule

// File: tb/tb_vdp_super_palette.sv
// Self-checking bench for vdp_super_palette: vector table, directed corner cases,
// and random CPU/pixel traffic against a byte-stream palette model.
module tb_vdp_super_palette;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic init_done;

   vdp_super_palette_if bus();

   vdp_super_palette dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [23:0] rgb;
   } vec_t;

   // Model: palette array, bytes pending for the current entry, and a linear readback byte cursor.
   logic [23:0] model [256];
   logic [7:0]  pend [$];
   int          wr_idx;
   int          rd_pos;
   logic [7:0]  rd_exp;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 256; i++) model[i] = {3{8'(i)}};
      pend.delete();
      wr_idx = 0;
      rd_pos = 0;
      rd_exp = 8'h00;
   endfunction

`ifdef VDP_SUPER_PALETTE_READBACK_EN
   function automatic logic [7:0] rd_byte(input int pos);
      logic [23:0] e;
      e = model[pos / 3];
      case (pos % 3)
         0:       return e[23:16];
         1:       return e[15:8];
         default: return e[7:0];
      endcase
   endfunction
`endif

   // One clock with the given strobes; the model is advanced for the same edge.
   task automatic cycle(input bit iw, input logic [7:0] idx, input bit dw,
                        input logic [7:0] d, input bit rr);
      bus.cpu_index_wr = iw;
      bus.cpu_index    = idx;
      bus.cpu_data_wr  = dw;
      bus.cpu_data     = d;
      bus.cpu_rd_req   = rr;
`ifdef VDP_SUPER_PALETTE_READBACK_EN
      if (rr && !iw) begin
         rd_exp = rd_byte(rd_pos);
         rd_pos = (rd_pos + 1) % 768;
      end
      if (iw) rd_pos = int'(idx) * 3;
`endif
      if (iw) begin
         wr_idx = int'(idx);
         pend.delete();
      end
      if (dw) begin
         pend.push_back(d);
         if (pend.size() == 3) begin
            model[wr_idx] = {pend[0], pend[1], pend[2]};
            wr_idx = (wr_idx + 1) % 256;
            pend.delete();
         end
      end
      tick();
      bus.cpu_index_wr = 1'b0;
      bus.cpu_data_wr  = 1'b0;
      bus.cpu_rd_req   = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      cycle(1'b0, 8'h00, 1'b1, d, 1'b0);
   endtask

   task automatic set_index(input logic [7:0] i);
      cycle(1'b1, i, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic chk_px(input string name);
      chk(name, 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'(model[bus.palette_addr]));
   endtask

   task automatic look(input string name, input logic [7:0] a);
      bus.palette_addr = a;
      tick();
      chk_px(name);
   endtask

   // Count edges until init_done; optionally fire CPU strobes that must be dropped.
   task automatic wait_init(input bit inject, output int n);
      n = 0;
      while (init_done !== 1'b1 && n < 400) begin
         tick();
         n++;
         if (inject) begin
            bus.cpu_index_wr = (n == 10);
            bus.cpu_index    = 8'h03;
            bus.cpu_rd_req   = (n == 10);
            bus.cpu_data_wr  = (n >= 11 && n < 14);
            bus.cpu_data     = 8'hEE;
         end
      end
      bus.cpu_index_wr = 1'b0;
      bus.cpu_data_wr  = 1'b0;
      bus.cpu_rd_req   = 1'b0;
   endtask

   initial begin
      vec_t vecs [6];
      int n;
      logic [7:0] a;
      bit iw, dw, rr;

      bus.palette_addr = 8'h00;
      bus.cpu_index_wr = 1'b0;
      bus.cpu_index    = 8'h00;
      bus.cpu_data_wr  = 1'b0;
      bus.cpu_data     = 8'h00;
      bus.cpu_rd_req   = 1'b0;
      repeat (3) tick();
      chk("rst_rgb", 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'h0);
      chk("rst_done", 32'(init_done), 32'h0);
      chk("rst_rd", 32'(bus.cpu_rd_data), 32'h0);

      reset_n = 1'b1;
      wait_init(1'b1, n);
      chk("init_cycles", 32'(n), 32'd256);
      model_reset();
      chk("init_rd_hold", 32'(bus.cpu_rd_data), 32'h0);

      vecs[0] = '{8'h40, 24'h404040};
      vecs[1] = '{8'h00, 24'h000000};
      vecs[2] = '{8'hFF, 24'hFFFFFF};
      vecs[3] = '{8'h01, 24'h010101};
      vecs[4] = '{8'h80, 24'h808080};
      vecs[5] = '{8'h03, 24'h030303};
      for (int i = 0; i < 6; i++) begin
         bus.palette_addr = vecs[i].addr;
         tick();
         chk("grey_table", 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'(vecs[i].rgb));
      end

      // Strobes during init were dropped: writes land at index 0, entry 3 stays grey.
      wr(8'hA1); wr(8'hA2); wr(8'hA3);
      look("first_wr_e0", 8'h00);
      chk("first_wr_lit", 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'hA1A2A3);
      look("init_drop_e3", 8'h03);

      set_index(8'h05);
      wr(8'h11); wr(8'h22); wr(8'h33);
      look("t2_e5", 8'h05);
      chk("t2_e5_lit", 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'h112233);
      wr(8'h44); wr(8'h55); wr(8'h66);
      look("t2_next_e6", 8'h06);

      set_index(8'hFF);
      for (int i = 1; i <= 6; i++) wr(8'(i));
      look("t3_e255", 8'hFF);
      look("t3_e0", 8'h00);
      wr(8'h07); wr(8'h08); wr(8'h09);
      look("t3_wrap_e1", 8'h01);

      set_index(8'h14);
      wr(8'h5A);
      look("no_partial_r", 8'h14);
      wr(8'h5B);
      look("no_partial_rg", 8'h14);

      set_index(8'h07);
      wr(8'hAA);
      cycle(1'b1, 8'h09, 1'b1, 8'hBB, 1'b0);
      wr(8'hCC); wr(8'hDD);
      look("t4_e9", 8'h09);
      chk("t4_e9_lit", 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'hBBCCDD);
      look("t4_e7", 8'h07);

      set_index(8'h09);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
         chk("t6_readback", 32'(bus.cpu_rd_data), 32'(rd_exp));
      end

      bus.palette_addr = 8'h09;
      set_index(8'h09);
      wr(8'h01); wr(8'h02);
      chk_px("t5_before");
      wr(8'h03);
      chk_px("t5_bypass");
      chk("t5_bypass_lit", 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'h010203);

      for (int i = 0; i < 400; i++) begin
         a = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) a = 8'(wr_idx);
         bus.palette_addr = a;
         iw = ($urandom_range(0, 7) == 0);
         dw = ($urandom_range(0, 1) == 1);
         rr = !iw && !dw && ($urandom_range(0, 2) == 0);
         cycle(iw, 8'($urandom_range(0, 255)), dw, 8'($urandom_range(0, 255)), rr);
         chk_px("rand_rgb");
         chk("rand_rd", 32'(bus.cpu_rd_data), 32'(rd_exp));
      end

      // Reset in the middle of a partial triplet.
      set_index(8'h30);
      wr(8'h77);
      reset_n = 1'b0;
      #2;
      chk("mid_rst_rgb", 32'({bus.palette_r, bus.palette_g, bus.palette_b}), 32'h0);
      chk("mid_rst_done", 32'(init_done), 32'h0);
      chk("mid_rst_rd", 32'(bus.cpu_rd_data), 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      wait_init(1'b0, n);
      chk("reinit_cycles", 32'(n), 32'd256);
      model_reset();
      look("reinit_e40", 8'h40);
      look("reinit_e09", 8'h09);
      wr(8'h12); wr(8'h34); wr(8'h56);
      look("reinit_wr_e0", 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
